// File: rtl/dff_pair_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dff_pair_sequencer                                              |
// | Purpose  : Six-step self-test sequencer for a dual D flip-flop with        |
// |            active-low async set/reset; counts and reports Q/Qn mismatches. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dff_pair_sequencer #(
  parameter int HALF_PERIOD = 12000,
  parameter int CNT_W       = 16
) (
  input  logic       clk1,
  input  logic       reset1_n,
  input  logic       start,
  input  logic       abort,
  output logic       ff_clk1,
  output logic       ff_clk2,
  output logic       ff_d1,
  output logic       ff_d2,
  output logic       ff_set1_n,
  output logic       ff_set2_n,
  output logic       ff_rst1_n,
  output logic       ff_rst2_n,
  input  logic       q1,
  input  logic       q1_n,
  input  logic       q2,
  input  logic       q2_n,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [2:0] fail_step
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_EDGE   = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_hp_last   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [2:0]       c_last_step = 3'd5;
  localparam logic [2:0]       c_no_fail   = 3'd7;

  // Drive part of the step table: {rst_n, set_n, d1, d2, clocked}
  function automatic logic [4:0] step_drive(input logic [2:0] s);
    case (s)
      3'd0:    step_drive = 5'b0_1_0_0_0;
      3'd1:    step_drive = 5'b1_0_0_0_0;
      3'd2:    step_drive = 5'b1_1_0_1_1;
      3'd3:    step_drive = 5'b1_1_1_0_1;
      3'd4:    step_drive = 5'b1_1_0_1_0;
      3'd5:    step_drive = 5'b1_1_0_1_1;
      default: step_drive = 5'b1_1_0_0_0;
    endcase
  endfunction

  // Expected part of the step table: {exp_q1, exp_q2}
  function automatic logic [1:0] step_exp(input logic [2:0] s);
    case (s)
      3'd0:    step_exp = 2'b00;
      3'd1:    step_exp = 2'b11;
      3'd2:    step_exp = 2'b01;
      3'd3:    step_exp = 2'b10;
      3'd4:    step_exp = 2'b10;
      3'd5:    step_exp = 2'b01;
      default: step_exp = 2'b00;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_step;
  logic [2:0]       w_step_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_err_cnt;
  logic [7:0]       w_err_nxt;
  logic [2:0]       r_fail_step;
  logic [2:0]       w_fail_nxt;
  logic             r_pass;
  logic             w_pass_nxt;

  logic [3:0]       r_q_meta;
  logic [3:0]       r_q_sync;
  logic [1:0]       w_exp_cur;
  logic [3:0]       w_exp_lines;
  logic             w_mismatch;
  logic [4:0]       w_drv_nxt;

  logic             r_ff_clk;
  logic             r_ff_d1;
  logic             r_ff_d2;
  logic             r_ff_set_n;
  logic             r_ff_rst_n;

  always_ff @(posedge clk1 or negedge reset1_n) begin
    if (!reset1_n) begin
      r_q_meta <= 4'b0000;
      r_q_sync <= 4'b0000;
    end else begin
      r_q_meta <= {q1, q1_n, q2, q2_n};
      r_q_sync <= r_q_meta;
    end
  end

  assign w_exp_cur   = step_exp(r_step);
  assign w_exp_lines = {w_exp_cur[1], ~w_exp_cur[1], w_exp_cur[0], ~w_exp_cur[0]};
  assign w_mismatch  = (r_q_sync != w_exp_lines);

  always_ff @(posedge clk1 or negedge reset1_n) begin
    if (!reset1_n) begin
      r_state     <= S_IDLE;
      r_step      <= 3'd0;
      r_cnt       <= '0;
      r_err_cnt   <= 8'd0;
      r_fail_step <= c_no_fail;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_cnt   <= w_err_nxt;
      r_fail_step <= w_fail_nxt;
      r_pass      <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err_cnt;
    w_fail_nxt  = r_fail_step;
    w_pass_nxt  = r_pass;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_SETUP;
          w_step_nxt  = 3'd0;
          w_cnt_nxt   = '0;
          w_err_nxt   = 8'd0;
          w_fail_nxt  = c_no_fail;
          w_pass_nxt  = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_cnt == c_hp_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_EDGE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_EDGE: begin
        if (r_cnt == c_hp_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CHECK;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_CHECK: begin
        if (w_mismatch) begin
          w_err_nxt = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;
          if (r_fail_step == c_no_fail) begin
            w_fail_nxt = r_step;
          end
        end
        // pass is settled on entry to FINISH so it is valid alongside done
        if (r_step == c_last_step) begin
          w_state_nxt = S_FINISH;
          w_pass_nxt  = (w_err_nxt == 8'd0);
        end else begin
          w_state_nxt = S_SETUP;
          w_step_nxt  = r_step + 3'd1;
          w_cnt_nxt   = '0;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_step_nxt  = 3'd0;
      w_cnt_nxt   = '0;
      w_pass_nxt  = 1'b0;
    end
  end

  // Pin registers follow the next state so pins and state change on the same edge
  assign w_drv_nxt = step_drive(w_step_nxt);

  always_ff @(posedge clk1 or negedge reset1_n) begin
    if (!reset1_n) begin
      r_ff_clk   <= 1'b0;
      r_ff_d1    <= 1'b0;
      r_ff_d2    <= 1'b0;
      r_ff_set_n <= 1'b1;
      r_ff_rst_n <= 1'b1;
    end else begin
      case (w_state_nxt)
        S_SETUP, S_EDGE, S_CHECK: begin
          r_ff_clk   <= (w_state_nxt == S_EDGE) ? w_drv_nxt[0] : 1'b0;
          r_ff_d1    <= w_drv_nxt[2];
          r_ff_d2    <= w_drv_nxt[1];
          r_ff_set_n <= w_drv_nxt[3];
          r_ff_rst_n <= w_drv_nxt[4];
        end
        default: begin
          r_ff_clk   <= 1'b0;
          r_ff_d1    <= 1'b0;
          r_ff_d2    <= 1'b0;
          r_ff_set_n <= 1'b1;
          r_ff_rst_n <= 1'b1;
        end
      endcase
    end
  end

  assign ff_clk1   = r_ff_clk;
  assign ff_clk2   = r_ff_clk;
  assign ff_d1     = r_ff_d1;
  assign ff_d2     = r_ff_d2;
  assign ff_set1_n = r_ff_set_n;
  assign ff_set2_n = r_ff_set_n;
  assign ff_rst1_n = r_ff_rst_n;
  assign ff_rst2_n = r_ff_rst_n;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FINISH);
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign fail_step = r_fail_step;

endmodule
`default_nettype wire

// File: tb/tb_dff_pair_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dff_pair_sequencer                                           |
// | Purpose  : Directed-vector bench with a behavioural dual DFF and faults.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dff_pair_sequencer;

  logic       clk1 = 1'b0;
  logic       reset1_n;
  logic       start;
  logic       abort;
  logic       ff_clk1, ff_clk2, ff_d1, ff_d2;
  logic       ff_set1_n, ff_set2_n, ff_rst1_n, ff_rst2_n;
  logic       q1, q1_n, q2, q2_n;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [2:0] fail_step;

  int n_vec     = 0;
  int n_miscmp  = 0;
  int done_cnt  = 0;
  int mode      = 0;   // 0 good, 1 q2 stuck at 0, 2 q1/q1_n shorted high

  logic       m_q1 = 1'b0;
  logic       m_q2 = 1'b0;
  logic [7:0] pins;

  always #5 clk1 = ~clk1;

  dff_pair_sequencer #(.HALF_PERIOD(4), .CNT_W(16)) dut (
    .clk1(clk1), .reset1_n(reset1_n), .start(start), .abort(abort),
    .ff_clk1(ff_clk1), .ff_clk2(ff_clk2), .ff_d1(ff_d1), .ff_d2(ff_d2),
    .ff_set1_n(ff_set1_n), .ff_set2_n(ff_set2_n),
    .ff_rst1_n(ff_rst1_n), .ff_rst2_n(ff_rst2_n),
    .q1(q1), .q1_n(q1_n), .q2(q2), .q2_n(q2_n),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_step(fail_step)
  );

  // Dual DFF model: RST_n has priority over SET_n
  always @(posedge ff_clk1 or negedge ff_rst1_n or negedge ff_set1_n) begin
    if (!ff_rst1_n)      m_q1 <= 1'b0;
    else if (!ff_set1_n) m_q1 <= 1'b1;
    else                 m_q1 <= ff_d1;
  end

  always @(posedge ff_clk2 or negedge ff_rst2_n or negedge ff_set2_n) begin
    if (!ff_rst2_n)      m_q2 <= 1'b0;
    else if (!ff_set2_n) m_q2 <= 1'b1;
    else                 m_q2 <= ff_d2;
  end

  assign q1   = (mode == 2) ? 1'b1 : m_q1;
  assign q1_n = (mode == 2) ? 1'b1 : ~m_q1;
  assign q2   = (mode == 1) ? 1'b0 : m_q2;
  assign q2_n = ~m_q2;

  assign pins = {ff_clk1, ff_clk2, ff_d1, ff_d2, ff_set1_n, ff_set2_n, ff_rst1_n, ff_rst2_n};

  always @(posedge clk1) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string nm, input logic e_pass,
                                    input logic [7:0] e_err, input logic [2:0] e_fail);
    check_vec({nm, ":pins"}, {24'd0, pins}, 32'h0F);
    check_vec({nm, ":busy"}, {31'd0, busy}, 32'd0);
    check_vec({nm, ":done"}, {31'd0, done}, 32'd0);
    check_vec({nm, ":pass"}, {31'd0, pass}, {31'd0, e_pass});
    check_vec({nm, ":err"},  {24'd0, err_cnt}, {24'd0, e_err});
    check_vec({nm, ":fail"}, {29'd0, fail_step}, {29'd0, e_fail});
  endtask

  // Counts cycles after the accept cycle until done; probes pins at fixed points
  task automatic wait_done(input string nm, input bit release_start);
    int cyc = 0;
    do begin
      @(negedge clk1);
      cyc++;
      if (release_start && cyc == 1) start = 1'b0;
      case (cyc)
        1:  check_vec({nm, ":pins_s0"}, {24'd0, pins}, 32'h0C);
        10: check_vec({nm, ":pins_s1"}, {24'd0, pins}, 32'h03);
        20: check_vec({nm, ":busy_mid"}, {31'd0, busy}, 32'd1);
        23: check_vec({nm, ":pins_s2e"}, {24'd0, pins}, 32'hDF);
        32: check_vec({nm, ":pins_s3e"}, {24'd0, pins}, 32'hEF);
        41: check_vec({nm, ":pins_s4e"}, {24'd0, pins}, 32'h1F);
        default: ;
      endcase
    end while (!done && cyc < 200);
    check_vec({nm, ":done_lat"}, cyc, 32'd55);
  endtask

  task automatic run_once(input string nm, input logic [7:0] e_err,
                          input logic [2:0] e_fail, input logic e_pass);
    @(negedge clk1);
    start = 1'b1;
    wait_done(nm, 1'b1);
    check_vec({nm, ":err"},  {24'd0, err_cnt}, {24'd0, e_err});
    check_vec({nm, ":fail"}, {29'd0, fail_step}, {29'd0, e_fail});
    check_vec({nm, ":pass"}, {31'd0, pass}, {31'd0, e_pass});
    @(negedge clk1);
    check_vec({nm, ":busy_end"}, {31'd0, busy}, 32'd0);
    check_vec({nm, ":done_end"}, {31'd0, done}, 32'd0);
    check_vec({nm, ":pass_hold"}, {31'd0, pass}, {31'd0, e_pass});
  endtask

  initial begin
    int dc;
    reset1_n = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    repeat (3) @(negedge clk1);
    check_idle_outputs("reset", 1'b0, 8'd0, 3'd7);
    reset1_n = 1'b1;
    @(negedge clk1);

    mode = 0;
    run_once("good", 8'd0, 3'd7, 1'b1);
    repeat (5) @(negedge clk1);
    check_vec("good:pass_later", {31'd0, pass}, 32'd1);

    mode = 1;
    run_once("q2stuck", 8'd3, 3'd1, 1'b0);

    mode = 2;
    run_once("q1short", 8'd6, 3'd0, 1'b0);

    // Abort in EDGE of step 3 with q2 stuck: partial counts stay
    mode = 1;
    @(negedge clk1);
    start = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk1);
      if (i == 1) start = 1'b0;
    end
    check_vec("abort:pre_clk", {31'd0, ff_clk1}, 32'd1);
    dc = done_cnt;
    abort = 1'b1;
    @(negedge clk1);
    abort = 1'b0;
    check_idle_outputs("abort", 1'b0, 8'd2, 3'd1);
    repeat (70) @(negedge clk1);
    check_vec("abort:no_done", dc, done_cnt);

    // Start held high through two runs
    mode = 0;
    @(negedge clk1);
    start = 1'b1;
    wait_done("held1", 1'b0);
    check_vec("held1:pass", {31'd0, pass}, 32'd1);
    @(negedge clk1);
    check_vec("held:idle_gap", {31'd0, busy}, 32'd0);
    wait_done("held2", 1'b0);
    start = 1'b0;
    check_vec("held2:pass", {31'd0, pass}, 32'd1);
    repeat (2) @(negedge clk1);
    check_vec("held:stop", {31'd0, busy}, 32'd0);

    // One-cycle reset during step 2, then a clean run
    @(negedge clk1);
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk1);
      if (i == 1) start = 1'b0;
    end
    reset1_n = 1'b0;
    #1;
    check_idle_outputs("midreset", 1'b0, 8'd0, 3'd7);
    @(negedge clk1);
    reset1_n = 1'b1;
    run_once("after_rst", 8'd0, 3'd7, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
